// File: rtl/mem_arbiter.sv
// Shares one multi-cycle unified memory between the CPU fetch port and its load/store port.
// The arbiter latches one access, holds it for MEM_LAT cycles, and returns a one-cycle valid pulse.
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_hlt,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic              o_if_valid,
    output logic              o_if_stall,
    input  logic              i_d_req,
    input  logic              i_d_wr,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_d_valid,
    output logic              o_d_stall,
    output logic              o_mem_en,
    output logic              o_mem_wr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
    localparam logic [STV_W-1:0] STV_TOP  = STV_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [STV_W-1:0]  r_starve;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_if_valid;
    logic              r_d_valid;

    logic w_if_elig;
    logic w_d_elig;
    logic w_grant_if;
    logic w_grant_d;
    logic w_last;

    // A port whose valid is high this cycle is finishing and must not be re-granted yet.
    assign w_if_elig = i_if_req & ~r_if_valid & ~i_hlt;
    assign w_d_elig  = i_d_req & ~r_d_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_if  = 1'b0;
        w_grant_d   = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_if_elig && (!w_d_elig || r_starve == STV_TOP)) begin
                    w_grant_if  = 1'b1;
                    w_state_nxt = FETCH;
                end else if (w_d_elig) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = DATA;
                end
            end
            FETCH, DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_starve   <= '0;
            r_addr     <= '0;
            r_wr       <= 1'b0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            if (w_grant_if) begin
                r_addr   <= i_if_addr;
                r_wr     <= 1'b0;
                r_wdata  <= '0;
                r_cnt    <= '0;
                r_starve <= '0;
            end else if (w_grant_d) begin
                r_addr  <= i_d_addr;
                r_wr    <= i_d_wr;
                r_wdata <= i_d_wdata;
                r_cnt   <= '0;
                // Only data grants that actually bypassed a waiting fetch count toward starvation.
                if (w_if_elig && r_starve != STV_TOP) r_starve <= r_starve + 1'b1;
            end else if (r_state != IDLE) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_last) begin
                if (r_state == FETCH) begin
                    r_if_valid <= 1'b1;
                    r_if_rdata <= i_mem_rdata;
                end else begin
                    r_d_valid <= 1'b1;
                    if (!r_wr) r_d_rdata <= i_mem_rdata;
                end
            end
        end
    end

    assign o_mem_en    = (r_state != IDLE);
    assign o_mem_wr    = (r_state == DATA) & r_wr;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_if_rdata  = r_if_rdata;
    assign o_if_valid  = r_if_valid;
    assign o_d_rdata   = r_d_rdata;
    assign o_d_valid   = r_d_valid;
    assign o_if_stall  = i_if_req & ~r_if_valid;
    assign o_d_stall   = i_d_req & ~r_d_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: MEM_LAT=4, STARVE_MAX=4, with a small memory model
// that only presents real read data in the last access cycle.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        hlt;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_valid;
    logic        d_stall;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0]  m_cnt = 2'd0;
    logic [15:0] rd_key = 16'h0000;
    int          n_commit = 0;
    logic [15:0] c_addr = 16'h0;
    logic [15:0] c_data = 16'h0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(4), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .i_hlt(hlt),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(if_rdata),
        .o_if_valid(if_valid), .o_if_stall(if_stall),
        .i_d_req(d_req), .i_d_wr(d_wr), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .o_d_rdata(d_rdata), .o_d_valid(d_valid), .o_d_stall(d_stall),
        .o_mem_en(mem_en), .o_mem_wr(mem_wr), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    // Memory model: garbage except in the 4th access cycle; writes commit at the final edge.
    assign mem_rdata = (mem_en && m_cnt == 2'd3) ? (mem_addr ^ rd_key) : 16'hDEAD;
    always @(posedge clk) begin
        if (!rst_n || !mem_en) m_cnt <= 2'd0;
        else                   m_cnt <= m_cnt + 2'd1;
        if (rst_n && mem_en && mem_wr && m_cnt == 2'd3) begin
            n_commit <= n_commit + 1;
            c_addr   <= mem_addr;
            c_data   <= mem_wdata;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hlt = 1'b0; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
        cyc(); cyc();
        n_cmp++; if ({if_valid, d_valid, mem_en, mem_wr} !== 4'b0000) begin
            n_err++; $display("FAIL reset_ctrl got %b want 0000", {if_valid, d_valid, mem_en, mem_wr}); end
        n_cmp++; if ({if_rdata, d_rdata} !== 32'h0) begin
            n_err++; $display("FAIL reset_rdata got %h want 0", {if_rdata, d_rdata}); end
        n_cmp++; if ({if_stall, d_stall} !== 2'b00) begin
            n_err++; $display("FAIL reset_stall got %b want 00", {if_stall, d_stall}); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_single_fetch();
        rd_key = 16'hA133;
        if_req = 1'b1; if_addr = 16'h0010;
        #1;
        n_cmp++; if (if_stall !== 1'b1) begin
            n_err++; $display("FAIL fetch_stall0 got %b want 1", if_stall); end
        for (int k = 1; k <= 5; k++) begin
            cyc();
            if (k <= 4) begin
                n_cmp++; if ({mem_en, mem_wr, mem_addr, if_valid, if_stall} !== {2'b10, 16'h0010, 2'b01}) begin
                    n_err++; $display("FAIL fetch_access c%0d got en=%b wr=%b a=%h v=%b st=%b want en=1 wr=0 a=0010 v=0 st=1",
                                      k, mem_en, mem_wr, mem_addr, if_valid, if_stall); end
            end else begin
                n_cmp++; if ({mem_en, if_valid, if_stall, if_rdata} !== {3'b010, 16'hA123}) begin
                    n_err++; $display("FAIL fetch_done got en=%b v=%b st=%b rd=%h want en=0 v=1 st=0 rd=a123",
                                      mem_en, if_valid, if_stall, if_rdata); end
            end
        end
        if_req = 1'b0;
        cyc();
        n_cmp++; if (if_valid !== 1'b0) begin
            n_err++; $display("FAIL fetch_pulse got %b want 0", if_valid); end
    endtask

    task automatic test_store();
        int base;
        base = n_commit;
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0200; d_wdata = 16'hBEEF;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            if (k <= 4) begin
                n_cmp++; if ({mem_en, mem_wr, mem_addr, mem_wdata, d_stall} !== {2'b11, 16'h0200, 16'hBEEF, 1'b1}) begin
                    n_err++; $display("FAIL store_access c%0d got en=%b wr=%b a=%h wd=%h st=%b want en=1 wr=1 a=0200 wd=beef st=1",
                                      k, mem_en, mem_wr, mem_addr, mem_wdata, d_stall); end
            end else begin
                n_cmp++; if ({d_valid, d_stall, mem_en, mem_wr, d_rdata} !== {4'b1000, 16'h0000}) begin
                    n_err++; $display("FAIL store_done got v=%b st=%b en=%b wr=%b rd=%h want v=1 st=0 en=0 wr=0 rd=0000",
                                      d_valid, d_stall, mem_en, mem_wr, d_rdata); end
                n_cmp++; if ({n_commit - base, c_addr, c_data} !== {32'd1, 16'h0200, 16'hBEEF}) begin
                    n_err++; $display("FAIL store_commit got n=%0d a=%h d=%h want n=1 a=0200 d=beef",
                                      n_commit - base, c_addr, c_data); end
            end
        end
        d_req = 1'b0; d_wr = 1'b0;
        cyc();
    endtask

    task automatic test_simultaneous();
        rd_key = 16'h1111;
        if_req = 1'b1; if_addr = 16'h0020;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0300;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (k <= 4) begin
                n_cmp++; if ({mem_en, mem_addr, if_stall, d_stall} !== {1'b1, 16'h0300, 2'b11}) begin
                    n_err++; $display("FAIL simul_data c%0d got en=%b a=%h want en=1 a=0300", k, mem_en, mem_addr); end
            end else if (k == 5) begin
                n_cmp++; if ({d_valid, if_valid, mem_en, d_rdata} !== {3'b100, 16'h1211}) begin
                    n_err++; $display("FAIL simul_dvalid got dv=%b iv=%b en=%b rd=%h want dv=1 iv=0 en=0 rd=1211",
                                      d_valid, if_valid, mem_en, d_rdata); end
                d_req = 1'b0;
            end else if (k <= 9) begin
                n_cmp++; if ({mem_en, mem_addr, if_valid, d_valid} !== {1'b1, 16'h0020, 2'b00}) begin
                    n_err++; $display("FAIL simul_fetch c%0d got en=%b a=%h want en=1 a=0020", k, mem_en, mem_addr); end
            end else begin
                n_cmp++; if ({if_valid, if_rdata, d_rdata} !== {1'b1, 16'h1131, 16'h1211}) begin
                    n_err++; $display("FAIL simul_ivalid got iv=%b ird=%h drd=%h want iv=1 ird=1131 drd=1211",
                                      if_valid, if_rdata, d_rdata); end
            end
        end
        if_req = 1'b0;
        cyc();
    endtask

    task automatic test_halt();
        rd_key = 16'h1111;
        if_req = 1'b1; if_addr = 16'h0040;
        for (int k = 1; k <= 19; k++) begin
            cyc();
            if (k == 1) hlt = 1'b1;
            if (k <= 4) begin
                n_cmp++; if ({mem_en, mem_addr} !== {1'b1, 16'h0040}) begin
                    n_err++; $display("FAIL halt_inflight c%0d got en=%b a=%h want en=1 a=0040", k, mem_en, mem_addr); end
            end else if (k == 5) begin
                n_cmp++; if ({if_valid, if_rdata} !== {1'b1, 16'h1151}) begin
                    n_err++; $display("FAIL halt_complete got v=%b rd=%h want v=1 rd=1151", if_valid, if_rdata); end
            end else if (k <= 10 || k >= 16) begin
                n_cmp++; if ({mem_en, if_valid, if_stall} !== 3'b001) begin
                    n_err++; $display("FAIL halt_blocked c%0d got en=%b v=%b st=%b want en=0 v=0 st=1", k, mem_en, if_valid, if_stall); end
            end else if (k <= 14) begin
                n_cmp++; if ({mem_en, mem_addr} !== {1'b1, 16'h0500}) begin
                    n_err++; $display("FAIL halt_data c%0d got en=%b a=%h want en=1 a=0500", k, mem_en, mem_addr); end
            end else begin
                n_cmp++; if ({d_valid, d_rdata, if_valid} !== {1'b1, 16'h1411, 1'b0}) begin
                    n_err++; $display("FAIL halt_dvalid got v=%b rd=%h iv=%b want v=1 rd=1411 iv=0", d_valid, d_rdata, if_valid); end
            end
            if (k == 10) begin d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0500; end
            if (k == 15) d_req = 1'b0;
        end
        if_req = 1'b0; hlt = 1'b0;
        cyc();
    endtask

    task automatic test_starvation();
        logic [15:0] gaddr [5];
        logic [2:0]  gstarve [5];
        logic        prev_en;
        int          ng;
        logic        seen;
        rd_key = 16'h1111;
        if_req = 1'b1; if_addr = 16'h0060;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0700;
        hlt = 1'b0;
        prev_en = mem_en;
        ng = 0;
        for (int i = 0; i < 5; i++) begin gaddr[i] = 16'h0; gstarve[i] = 3'd7; end
        // Halt fetch exactly during data-valid cycles so fetch cannot slip in at those edges.
        for (int k = 0; k < 80 && ng < 5; k++) begin
            cyc();
            if (mem_en && !prev_en) begin
                gaddr[ng]   = mem_addr;
                gstarve[ng] = dut.r_starve;
                ng++;
            end
            prev_en = mem_en;
            hlt = d_valid;
        end
        d_req = 1'b0; hlt = 1'b0;
        n_cmp++; if (ng !== 5) begin
            n_err++; $display("FAIL starve_timeout got %0d grants want 5", ng); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if ({gaddr[i], gstarve[i]} !== {16'h0700, 3'(i + 1)}) begin
                n_err++; $display("FAIL starve_dgrant%0d got a=%h s=%0d want a=0700 s=%0d", i, gaddr[i], gstarve[i], i + 1); end
        end
        n_cmp++; if ({gaddr[4], gstarve[4]} !== {16'h0060, 3'd0}) begin
            n_err++; $display("FAIL starve_fgrant got a=%h s=%0d want a=0060 s=0", gaddr[4], gstarve[4]); end
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            cyc();
            seen = if_valid;
        end
        n_cmp++; if ({seen, if_rdata} !== {1'b1, 16'h1171}) begin
            n_err++; $display("FAIL starve_fvalid got seen=%b rd=%h want seen=1 rd=1171", seen, if_rdata); end
        if_req = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid();
        logic any_v;
        rd_key = 16'h1111;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0800;
        cyc(); cyc(); cyc();
        rst_n = 1'b0;
        d_req = 1'b0;
        cyc();
        n_cmp++; if ({mem_en, d_valid, d_rdata, if_rdata} !== {2'b00, 32'h0}) begin
            n_err++; $display("FAIL rstmid_clear got en=%b v=%b drd=%h ird=%h want en=0 v=0 drd=0000 ird=0000",
                              mem_en, d_valid, d_rdata, if_rdata); end
        rst_n = 1'b1;
        any_v = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            any_v = any_v | d_valid | mem_en;
        end
        n_cmp++; if (any_v !== 1'b0) begin
            n_err++; $display("FAIL rstmid_ghost got %b want 0", any_v); end
        d_req = 1'b1; d_addr = 16'h0900;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            if (k == 5) begin
                n_cmp++; if ({d_valid, d_rdata} !== {1'b1, 16'h1811}) begin
                    n_err++; $display("FAIL rstmid_fresh got v=%b rd=%h want v=1 rd=1811", d_valid, d_rdata); end
            end
        end
        d_req = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store();
        test_simultaneous();
        test_halt();
        test_starvation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end
endmodule
